// File: rtl/starflux_pkg.sv
// rtl/starflux_pkg.sv - shared screen, colour and bullet frame reader state definitions
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BG     = 3'b000;
    localparam logic [2:0] COL_PLAYER = 3'b111;
    localparam logic [2:0] COL_ENEMY  = 3'b100;
    localparam logic [2:0] COL_BOTH   = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } bfr_state_t;

endpackage

// File: rtl/bullet_row_serializer.sv
// rtl/bullet_row_serializer.sv - holds one grid row snapshot and hands out cells in column order
module bullet_row_serializer #(
    parameter int GRID_W = 118
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [GRID_W-1:0] i_player_row,
    input  logic [GRID_W-1:0] i_enemy_row,
    output logic              o_p,
    output logic              o_e,
    output logic              o_last
);

    localparam int IW = $clog2(GRID_W + 1);

    logic [GRID_W-1:0] r_p;
    logic [GRID_W-1:0] r_e;
    logic [IW-1:0]     r_idx;

    // Cell handed out on this edge: column 0 comes straight off the read bus
    // during load so it can be plotted the cycle after the snapshot is taken;
    // later columns come from the head of the shifted snapshot.
    assign o_p    = i_load ? i_player_row[0] : r_p[0];
    assign o_e    = i_load ? i_enemy_row[0]  : r_e[0];
    // r_idx is the column of the next pending cell, so reaching GRID_W means
    // the column just handed out was the last one of the row.
    assign o_last = (r_idx == IW'(GRID_W));

    // Snapshot the row on load (minus column 0, already consumed), shift on step
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_p   <= '0;
            r_e   <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_p   <= i_player_row >> 1;
            r_e   <= i_enemy_row >> 1;
            r_idx <= IW'(1);
        end else if (i_step) begin
            r_p   <= r_p >> 1;
            r_e   <= r_e >> 1;
            r_idx <= r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/bullet_frame_reader.sv
// rtl/bullet_frame_reader.sv - scans the bullet grids row by row into VGA pixel writes
module bullet_frame_reader #(
    parameter int         GRID_W     = 118,
    parameter int         GRID_H     = 120,
    parameter int         X_OFFSET   = 21,
    parameter logic [2:0] COL_PLAYER = starflux_pkg::COL_PLAYER,
    parameter logic [2:0] COL_ENEMY  = starflux_pkg::COL_ENEMY,
    parameter logic [2:0] COL_BOTH   = starflux_pkg::COL_BOTH,
    parameter logic [2:0] COL_BG     = starflux_pkg::COL_BG
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              hold,
    output logic              row_rd,
    output logic [6:0]        row_addr,
    input  logic [GRID_W-1:0] player_row,
    input  logic [GRID_W-1:0] enemy_row,
    output logic              vga_plot,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              coll,
    output logic [7:0]        coll_count,
    output logic              busy,
    output logic              done
);

    import starflux_pkg::*;

    bfr_state_t r_state, w_state_nx;
    logic [6:0] r_row, w_row_nx;
    logic       r_row_rd, w_row_rd_nx;
    logic       r_plot, w_plot_nx;
    logic [7:0] r_x, w_x_nx;
    logic [6:0] r_y, w_y_nx;
    logic [2:0] r_colour, w_colour_nx;
    logic       r_coll, w_coll_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic       r_busy, w_busy_nx;
    logic       r_done, w_done_nx;

    logic       w_load;
    logic       w_step;
    logic       w_emit;
    logic       w_p;
    logic       w_e;
    logic       w_last;

    bullet_row_serializer #(
        .GRID_W (GRID_W)
    ) u_ser (
        .clk          (clk),
        .resetn       (resetn),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_player_row (player_row),
        .i_enemy_row  (enemy_row),
        .o_p          (w_p),
        .o_e          (w_e),
        .o_last       (w_last)
    );

    // Next state and next value of every registered output; outputs hold unless a cell is emitted
    always_comb begin
        w_state_nx  = r_state;
        w_row_nx    = r_row;
        w_row_rd_nx = 1'b0;
        w_plot_nx   = 1'b0;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_colour_nx = r_colour;
        w_coll_nx   = 1'b0;
        w_cnt_nx    = r_cnt;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_emit      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx  = ST_REQ;
                    w_row_nx    = '0;
                    w_row_rd_nx = 1'b1;
                    w_cnt_nx    = '0;
                    w_busy_nx   = 1'b1;
                end
            end
            ST_REQ: begin
                w_state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                w_load     = 1'b1;
                w_emit     = 1'b1;
                w_x_nx     = 8'(X_OFFSET);
                w_y_nx     = r_row;
                w_state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                if (!hold) begin
                    if (w_last) begin
                        if (r_row == 7'(GRID_H - 1)) begin
                            w_state_nx = ST_DONE;
                            w_done_nx  = 1'b1;
                            w_busy_nx  = 1'b0;
                        end else begin
                            w_state_nx  = ST_REQ;
                            w_row_nx    = r_row + 7'd1;
                            w_row_rd_nx = 1'b1;
                        end
                    end else begin
                        w_step = 1'b1;
                        w_emit = 1'b1;
                        w_x_nx = r_x + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_emit) begin
            w_plot_nx = 1'b1;
            w_coll_nx = w_p & w_e;
            case ({w_p, w_e})
                2'b11:   w_colour_nx = COL_BOTH;
                2'b10:   w_colour_nx = COL_PLAYER;
                2'b01:   w_colour_nx = COL_ENEMY;
                default: w_colour_nx = COL_BG;
            endcase
            if (w_p && w_e && (r_cnt != 8'hFF)) begin
                w_cnt_nx = r_cnt + 8'd1;
            end
        end
    end

    // State and output registers; reset clears everything, aborting any frame without a done pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_row_rd <= 1'b0;
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_coll   <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_row    <= w_row_nx;
            r_row_rd <= w_row_rd_nx;
            r_plot   <= w_plot_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_colour <= w_colour_nx;
            r_coll   <= w_coll_nx;
            r_cnt    <= w_cnt_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign row_rd     = r_row_rd;
    assign row_addr   = r_row;
    assign vga_plot   = r_plot;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign coll       = r_coll;
    assign coll_count = r_cnt;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bullet_frame_reader.sv
// tb/tb_bullet_frame_reader.sv - directed self-checking bench for bullet_frame_reader
module tb_bullet_frame_reader;

    localparam int GW = 118;
    localparam int GH = 120;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          hold;
    logic          row_rd;
    logic [6:0]    row_addr;
    logic [GW-1:0] player_row;
    logic [GW-1:0] enemy_row;
    logic          vga_plot;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          coll;
    logic [7:0]    coll_count;
    logic          busy;
    logic          done;

    bullet_frame_reader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .hold       (hold),
        .row_rd     (row_rd),
        .row_addr   (row_addr),
        .player_row (player_row),
        .enemy_row  (enemy_row),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .coll       (coll),
        .coll_count (coll_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Grid storage: read address latched on row_rd, data shows up the next cycle
    logic [GW-1:0] mem_p [GH];
    logic [GW-1:0] mem_e [GH];
    logic [GW-1:0] exp_p [GH];
    logic [GW-1:0] exp_e [GH];
    logic [6:0]    rd_q = '0;

    always @(posedge clk) if (row_rd) rd_q <= row_addr;
    assign player_row = mem_p[rd_q];
    assign enemy_row  = mem_e[rd_q];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {26'd0, row_rd, row_addr, vga_plot, vga_x, vga_y, vga_colour, coll, coll_count, busy, done};
    endfunction

    task automatic clear_grid();
        for (int i = 0; i < GH; i++) begin
            mem_p[i] = '0;
            mem_e[i] = '0;
        end
    endtask

    task automatic sync_exp();
        for (int i = 0; i < GH; i++) begin
            exp_p[i] = mem_p[i];
            exp_e[i] = mem_e[i];
        end
    endtask

    // Plot monitor: every plot must be the next cell in raster order with the expected colour
    bit mon_en   = 1'b0;
    int plot_idx = 0;
    int n_rd     = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (row_rd) n_rd++;
            if (vga_plot) begin
                if (plot_idx < GW * GH) begin
                    int r, c;
                    logic p, e;
                    logic [2:0] col;
                    r = plot_idx / GW;
                    c = plot_idx % GW;
                    p = exp_p[r][c];
                    e = exp_e[r][c];
                    col = (p && e) ? 3'b110 : p ? 3'b111 : e ? 3'b100 : 3'b000;
                    check_vec("pix", {45'd0, vga_x, vga_y, vga_colour, coll},
                              {45'd0, 8'(21 + c), 7'(r), col, p & e});
                end
                plot_idx++;
            end else begin
                check_vec("coll_idle", {63'd0, coll}, 64'd0);
            end
        end
    end

    // One frame from the current negedge; returns at the negedge after done (IDLE again)
    task automatic run_frame(input int exp_done, input logic [7:0] exp_cnt, input bit do_hold,
                             input bit do_chg, input bit busy_start, input bit chain, input int abort_at);
        int n;
        bit seen;
        plot_idx = 0;
        n_rd     = 0;
        mon_en   = 1'b1;
        start    = 1'b1;
        seen     = 1'b0;
        for (n = 1; n <= 20000; n++) begin
            @(negedge clk);
            start = busy_start && (n >= 500) && (n <= 502);
            if (do_hold) begin
                if (n >= 54 && n <= 57)
                    check_vec("hold_stall", {55'd0, vga_plot, vga_x}, {55'd0, 1'b0, 8'd71});
                hold = (n >= 53) && (n <= 56);
            end
            if (do_chg && n == 300) mem_p[2] = ~mem_p[2];
            if (abort_at > 0 && n == abort_at) begin
                mon_en = 1'b0;
                resetn = 1'b0;
                @(negedge clk);
                check_vec("abort_reset", outs(), 64'd0);
                resetn = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (done) seen = 1'b1;
                end
                check_vec("abort_no_done", {63'd0, seen}, 64'd0);
                check_vec("abort_idle", {63'd0, busy}, 64'd0);
                return;
            end
            if (done) break;
        end
        check_vec("done_cycle", 64'(n), 64'(exp_done));
        check_vec("busy_at_done", {63'd0, busy}, 64'd0);
        check_vec("coll_count", {56'd0, coll_count}, {56'd0, exp_cnt});
        if (chain) start = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        check_vec("plot_total", 64'(plot_idx), 64'(GW * GH));
        check_vec("row_rd_total", 64'(n_rd), 64'(GH));
        check_vec("done_pulse", {62'd0, done, busy}, 64'd0);
        check_vec("count_hold", {56'd0, coll_count}, {56'd0, exp_cnt});
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        clear_grid();
        sync_exp();
        repeat (3) @(negedge clk);
        check_vec("reset_outs", outs(), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_vec("idle_outs", outs(), 64'd0);

        // Empty grid
        run_frame(14401, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Single bullets, two collisions, hold stall, late row-2 change, start while busy
        clear_grid();
        mem_p[5][0]    = 1'b1;
        mem_e[119][117] = 1'b1;
        mem_p[3][10]   = 1'b1;
        mem_e[3][10]   = 1'b1;
        mem_p[7][10]   = 1'b1;
        mem_e[7][10]   = 1'b1;
        mem_p[2]       = {59{2'b10}};
        sync_exp();
        run_frame(14405, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        // Every cell collides, started back-to-back from the cycle after done
        for (int i = 0; i < GH; i++) begin
            mem_p[i] = '1;
            mem_e[i] = '1;
        end
        sync_exp();
        run_frame(14401, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset during row 60
        clear_grid();
        sync_exp();
        run_frame(0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3 + 60 * (GW + 2) + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
